mem_pattern_tester: RTL
=======================

MEM_PATTERN_TESTER -- requirements
Module: mem_pattern_tester

Interface
REQ-001 SHALL have parameter AW, default 23, meaning memory address width.
REQ-002 SHALL have parameter DW, default 16, meaning memory data width (DW >= 2).
REQ-003 SHALL have parameter LAST_ADDR, default 2**AW-1, meaning highest address tested.
REQ-004 SHALL have parameter LFSR_POLY, default 16'hB400, meaning Galois feedback mask (low DW bits used).
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning nonzero LFSR start value.
REQ-006 SHALL have parameter TMO, default 255, meaning max cycles awaiting read data.
REQ-007 SHALL have ports, one per line:
 CLK  in  1  sole clock, rising edge
 RST_X  in  1  reset, asynchronous, active-low
 START  in  1  one-cycle pulse, begins test (IDLE or DONE only)
 MODE  in  2  pattern: 0 incr, 1 addr-as-data, 2 walking-one, 3 LFSR
 PASSES  in  8  pass count; 0 = run until STOP
 STOP  in  1  abort request
 MEM_WADDR  out  AW  write address
 MEM_RADDR  out  AW  read address
 MEM_DIN  out  DW  write data
 MEM_WREQ  out  1  write request pulse
 MEM_RREQ  out  1  read request pulse
 MEM_BUSY  in  1  controller busy
 MEM_DOUT  in  DW  read data
 MEM_DOUTEN  in  1  read data valid, one cycle
 TESTING  out  1  high outside IDLE/DONE
 DONE  out  1  high in DONE
 ERR  out  1  sticky: any mismatch or timeout this run
 TIMEOUT  out  1  sticky: any read timeout this run
 ERR_CNT  out  16  saturating error count
 FAIL_ADDR  out  AW  address of first error
 FAIL_DATA  out  DW  data read at first error (0 on timeout)
 PASS_CNT  out  8  completed passes, wraps 255->0

Function
REQ-008 SHALL implement states IDLE, WRITE, READ, CHECK, DONE.
REQ-009 IDLE/DONE + START SHALL latch MODE and PASSES, clear ERR, TIMEOUT, ERR_CNT, FAIL_ADDR, FAIL_DATA, PASS_CNT, zero both addresses, reseed generator, enter WRITE next cycle.
REQ-010 START outside IDLE/DONE SHALL be ignored.
REQ-011 Requests SHALL be one-cycle pulses, asserted only in a cycle where MEM_BUSY is low and no request was asserted the previous cycle; WREQ and RREQ never both high.
REQ-012 WRITE: cycle after each MEM_WREQ, MEM_WADDR SHALL increment; after write at LAST_ADDR, MEM_WADDR wraps to 0, generator reseeds, state goes READ.
REQ-013 READ: after MEM_RREQ, MEM_RADDR SHALL increment (wrap to 0 after LAST_ADDR), state goes CHECK.
REQ-014 CHECK: on MEM_DOUTEN, compare MEM_DOUT with expected word for that address; mismatch is an error; return to READ, or end-of-pass if address was LAST_ADDR.
REQ-015 CHECK SHALL count cycles; if TMO cycles pass without MEM_DOUTEN, record error, set TIMEOUT, proceed as if data arrived.
REQ-016 Error SHALL set ERR, increment ERR_CNT saturating at 16'hFFFF; first error of run SHALL load FAIL_ADDR/FAIL_DATA, later errors SHALL not.
REQ-017 Pattern word k (index k=address): mode 0 = (k+1) mod 2**DW; mode 1 = k[DW-1:0] zero-extended; mode 2 = 1 << (k mod DW); mode 3 = LFSR state after k steps from LFSR_SEED.
REQ-018 On odd-numbered passes (PASS_CNT[0]=1) written and expected data SHALL be bitwise inverted.
REQ-019 End-of-pass SHALL increment PASS_CNT; if PASSES!=0 and new PASS_CNT==PASSES go DONE, else reseed and enter WRITE.
REQ-020 STOP in WRITE/READ SHALL go DONE next cycle, no further requests; STOP in CHECK SHALL take effect after data or timeout, that read still checked.
REQ-021 DONE SHALL hold all status until next START.

Reset
REQ-022 RST_X low SHALL asynchronously force IDLE, all outputs 0, counters 0, regardless of state; an in-flight read is abandoned.

Verification
REQ-023 AW=4, LAST_ADDR=15, MODE=0, PASSES=1, ideal memory -> 16 writes data 1..16, 16 reads, DONE=1, ERR=0, PASS_CNT=1.
REQ-024 Same, PASSES=2 -> pass 2 writes ~1..~16 (16'hFFFE..16'hFFEF), PASS_CNT=2, ERR=0.
REQ-025 MODE=2, memory bit 3 stuck-0 at addr 3 -> ERR=1, ERR_CNT=1, FAIL_ADDR=3, FAIL_DATA=16'h0000.
REQ-026 Memory never asserts DOUTEN at addr 5, TMO=8 -> TIMEOUT=1, ERR_CNT=1, FAIL_ADDR=5, FAIL_DATA=0, test finishes.
REQ-027 PASSES=0, STOP mid-WRITE -> DONE next cycle, no further MEM_WREQ; START again clears ERR_CNT and PASS_CNT.
REQ-028 RST_X low during CHECK with MEM_BUSY high -> outputs 0 immediately, IDLE, no requests after release until START.

Source files
------------

// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: writes a pattern over an address range,
// reads it back and checks it, over one or more passes.
module mem_pattern_tester #(
   parameter int              AW        = 23,
   parameter int              DW        = 16,
   parameter logic [AW-1:0]   LAST_ADDR = {AW{1'b1}},
   parameter logic [DW-1:0]   LFSR_POLY = DW'(16'hB400),
   parameter logic [DW-1:0]   LFSR_SEED = DW'(16'hACE1),
   parameter int              TMO       = 255
) (
   input  logic          CLK,
   input  logic          RST_X,
   input  logic          START,
   input  logic [1:0]    MODE,
   input  logic [7:0]    PASSES,
   input  logic          STOP,
   output logic [AW-1:0] MEM_WADDR,
   output logic [AW-1:0] MEM_RADDR,
   output logic [DW-1:0] MEM_DIN,
   output logic          MEM_WREQ,
   output logic          MEM_RREQ,
   input  logic          MEM_BUSY,
   input  logic [DW-1:0] MEM_DOUT,
   input  logic          MEM_DOUTEN,
   output logic          TESTING,
   output logic          DONE,
   output logic          ERR,
   output logic          TIMEOUT,
   output logic [15:0]   ERR_CNT,
   output logic [AW-1:0] FAIL_ADDR,
   output logic [DW-1:0] FAIL_DATA,
   output logic [7:0]    PASS_CNT
);

   localparam int TW = (TMO < 2) ? 1 : $clog2(TMO);
   localparam logic [DW-1:0] ONE = DW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_CHECK, S_DONE
   } state_t;

   state_t        state, state_nx;
   logic [1:0]    mode_q;
   logic [7:0]    passes_q;
   logic [AW-1:0] waddr, raddr, caddr;
   logic [DW-1:0] lfsr, lfsr_nx;
   logic          req_q, stop_q;
   logic [TW-1:0] tcnt;
   logic          err_q, tmo_q;
   logic [15:0]   err_cnt;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;
   logic [7:0]    pass_cnt, pass_inc;
   logic [AW-1:0] pa;
   logic [DW-1:0] ka, pat;
   logic [31:0]   sh;
   logic          can_req, wreq, rreq, start_ok;
   logic          tmo_hit, got, mis, last_chk;

   assign can_req  = !MEM_BUSY && !req_q && !STOP;
   assign wreq     = (state == S_WRITE) && can_req;
   assign rreq     = (state == S_READ) && can_req;
   assign start_ok = START && (state == S_IDLE || state == S_DONE);
   assign tmo_hit  = (state == S_CHECK) && !MEM_DOUTEN
                     && (tcnt == TW'(TMO - 1));
   assign got      = (state == S_CHECK) && (MEM_DOUTEN || tmo_hit);
   assign mis      = got && (tmo_hit || MEM_DOUT != pat);
   assign last_chk = (caddr == LAST_ADDR);
   assign pass_inc = pass_cnt + 8'd1;

   // Pattern word for the address being written or checked
   always_comb begin
      pa  = (state == S_CHECK) ? caddr : waddr;
      ka  = DW'(pa);
      sh  = 32'(pa) % 32'(DW);
      pat = '0;
      unique case (mode_q)
         2'd0: pat = ka + ONE;
         2'd1: pat = ka;
         2'd2: pat = ONE << sh;
         2'd3: pat = lfsr;
      endcase
      if (pass_cnt[0]) pat = ~pat;
      lfsr_nx = {1'b0, lfsr[DW-1:1]} ^ (lfsr[0] ? LFSR_POLY : '0);
   end

   // Next-state selection
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE:
            if (START) state_nx = S_WRITE;
         S_WRITE:
            if (STOP) state_nx = S_DONE;
            else if (wreq && waddr == LAST_ADDR) state_nx = S_READ;
         S_READ:
            if (STOP) state_nx = S_DONE;
            else if (rreq) state_nx = S_CHECK;
         S_CHECK:
            if (got) begin
               if (STOP || stop_q) state_nx = S_DONE;
               else if (!last_chk) state_nx = S_READ;
               else if (passes_q != 8'd0 && pass_inc == passes_q)
                  state_nx = S_DONE;
               else state_nx = S_WRITE;
            end
         default: state_nx = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Address, generator and status datapath
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         mode_q    <= '0;
         passes_q  <= '0;
         waddr     <= '0;
         raddr     <= '0;
         caddr     <= '0;
         lfsr      <= '0;
         req_q     <= 1'b0;
         stop_q    <= 1'b0;
         tcnt      <= '0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         pass_cnt  <= '0;
      end else begin
         req_q <= wreq || rreq;
         if (start_ok) begin
            mode_q    <= MODE;
            passes_q  <= PASSES;
            waddr     <= '0;
            raddr     <= '0;
            lfsr      <= LFSR_SEED;
            stop_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass_cnt  <= '0;
         end
         if (wreq) begin
            if (waddr == LAST_ADDR) begin
               waddr <= '0;
               lfsr  <= LFSR_SEED;
            end else begin
               waddr <= waddr + 1'b1;
               lfsr  <= lfsr_nx;
            end
         end
         if (rreq) begin
            caddr <= raddr;
            raddr <= (raddr == LAST_ADDR) ? '0 : raddr + 1'b1;
            tcnt  <= '0;
         end
         if (state == S_CHECK) begin
            tcnt <= tcnt + 1'b1;
            if (STOP) stop_q <= 1'b1;
         end
         if (got) begin
            lfsr   <= lfsr_nx;
            stop_q <= 1'b0;
            if (mis) begin
               err_q <= 1'b1;
               if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
               if (!err_q) begin
                  fail_addr <= caddr;
                  fail_data <= tmo_hit ? '0 : MEM_DOUT;
               end
            end
            if (tmo_hit) tmo_q <= 1'b1;
            if (last_chk) begin
               pass_cnt <= pass_inc;
               lfsr     <= LFSR_SEED;
            end
         end
      end
   end

   assign MEM_WADDR = waddr;
   assign MEM_RADDR = raddr;
   assign MEM_DIN   = (state == S_WRITE) ? pat : '0;
   assign MEM_WREQ  = wreq;
   assign MEM_RREQ  = rreq;
   assign TESTING   = (state == S_WRITE) || (state == S_READ)
                      || (state == S_CHECK);
   assign DONE      = (state == S_DONE);
   assign ERR       = err_q;
   assign TIMEOUT   = tmo_q;
   assign ERR_CNT   = err_cnt;
   assign FAIL_ADDR = fail_addr;
   assign FAIL_DATA = fail_data;
   assign PASS_CNT  = pass_cnt;

endmodule
